// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load.
// Adds a one-cycle wrap pulse, a one-cycle rejected-load pulse and a saturating count of
// wrap events so that boundary behaviour can be observed directly at the ports.
// Priority at every edge: rst > load > counting (en) > hold.
module mod_updown_counter #(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned WRAP_W  = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              updown,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out,
  output logic              wrap,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // Elaboration-time guard on the configuration.
  if ((MODULUS < 2) || (WIDTH < 1) || (WIDTH > 31) || (MODULUS > (1 << WIDTH)) ||
      (WRAP_W < 1)) begin : gen_param_check
    $error("mod_updown_counter: illegal MODULUS/WIDTH/WRAP_W combination");
  end

  // Largest legal count value, computed at WIDTH bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  // When MODULUS == 2**WIDTH every d_in is a legal load value.
  localparam bit FullRange = (MODULUS == (1 << WIDTH));
  localparam logic [WRAP_W-1:0] WrapSat = {WRAP_W{1'b1}};

  // Operation selected for the coming edge, already resolved by priority.
  typedef enum logic [2:0] {
    OpHold,
    OpLoad,
    OpReject,
    OpUp,
    OpDown
  } op_e;

  op_e op;

  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;

  logic load_ok;
  logic at_max;
  logic at_zero;
  logic wcnt_sat;

  assign load_ok  = FullRange || (d_in <= MaxVal);
  assign at_max   = (count_q == MaxVal);
  assign at_zero  = (count_q == '0);
  assign wcnt_sat = (wcnt_q == WrapSat);

  // Resolve load/enable/direction into a single operation; reset is applied in the register.
  always_comb begin
    op = OpHold;
    if (load) begin
      op = load_ok ? OpLoad : OpReject;
    end else if (en) begin
      op = updown ? OpUp : OpDown;
    end
  end

  // Next count value and the pulse outputs for the resolved operation.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    unique case (op)
      OpHold: begin
        count_d = count_q;
      end
      OpLoad: begin
        count_d = d_in;
      end
      OpReject: begin
        // Rejected load consumes the edge: no count step even with en high.
        err_d = 1'b1;
      end
      OpUp: begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      OpDown: begin
        if (at_zero) begin
          count_d = MaxVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Wrap event counter advances on the same edge that raises wrap, and sticks at all-ones.
  always_comb begin
    wcnt_d = wcnt_q;
    if (wrap_d && !wcnt_sat) begin
      wcnt_d = wcnt_q + WRAP_W'(1);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign d_out    = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
  assign wrap_cnt = wcnt_q;

  // Out-of-range counts are unreachable; wrap only ever lands on a range endpoint;
  // the two pulses can never coincide.
  always_ff @(posedge clock) begin
    if (!rst) begin
      assert (count_q <= MaxVal)
        else $error("mod_updown_counter: d_out out of range");
      assert (!wrap_q || (count_q == '0) || (count_q == MaxVal))
        else $error("mod_updown_counter: wrap raised away from a range endpoint");
      assert (!(wrap_q && err_q))
        else $error("mod_updown_counter: wrap and load_err raised together");
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter. Two instances share the stimulus: the default
// configuration, and one with WRAP_W=2 so wrap_cnt saturation is reachable quickly.
// Inputs are driven 1 time unit after posedge and outputs sampled 1 time unit after the
// following posedge.
module tb_mod_updown_counter;

  logic       clock;
  logic       rst;
  logic       en;
  logic       load;
  logic       updown;
  logic [3:0] d_in;
  logic [3:0] d_out;
  logic       wrap;
  logic       load_err;
  logic [7:0] wrap_cnt;
  logic [3:0] d_out_s;
  logic       wrap_s;
  logic       load_err_s;
  logic [1:0] wrap_cnt_s;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic       rst;
    logic       load;
    logic       en;
    logic       updown;
    logic [3:0] d_in;
  } stim_t;

  // Expected outputs of both instances for one edge; both see identical d_out/wrap/load_err.
  typedef struct packed {
    logic [3:0] d_out;
    logic       wrap;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
  } exp_t;

  exp_t sb[$];

  mod_updown_counter #(.MODULUS(12), .WIDTH(4), .WRAP_W(8)) dut (
    .clock    (clock),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .updown   (updown),
    .d_in     (d_in),
    .d_out    (d_out),
    .wrap     (wrap),
    .load_err (load_err),
    .wrap_cnt (wrap_cnt)
  );

  mod_updown_counter #(.MODULUS(12), .WIDTH(4), .WRAP_W(2)) dut_sat (
    .clock    (clock),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .updown   (updown),
    .d_in     (d_in),
    .d_out    (d_out_s),
    .wrap     (wrap_s),
    .load_err (load_err_s),
    .wrap_cnt (wrap_cnt_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stim_t mk_s(bit r, bit l, bit e, bit u, int d);
    stim_t s;
    s.rst    = r;
    s.load   = l;
    s.en     = e;
    s.updown = u;
    s.d_in   = 4'(d);
    return s;
  endfunction

  function automatic exp_t mk_e(int d, bit w, bit err, int cnt, int cnt_s);
    exp_t e;
    e.d_out = 4'(d);
    e.wrap  = w;
    e.err   = err;
    e.cnt   = 8'(cnt);
    e.cnt_s = 2'(cnt_s);
    return e;
  endfunction

  // Drive one edge's inputs, record the expectation, and advance to the sample point.
  task automatic drive(input stim_t s, input exp_t e);
    rst    = s.rst;
    load   = s.load;
    en     = s.en;
    updown = s.updown;
    d_in   = s.d_in;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.d_out = (d_out === d_out_s) ? d_out : 4'bxxxx;
    o.wrap  = (wrap === wrap_s) ? wrap : 1'bx;
    o.err   = (load_err === load_err_s) ? load_err : 1'bx;
    o.cnt   = wrap_cnt;
    o.cnt_s = wrap_cnt_s;
    return o;
  endfunction

  task automatic test_reset();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  got;
    exp_t  want;
    st[0] = mk_s(1, 0, 0, 0, 0);  ex[0] = mk_e(0, 0, 0, 0, 0);
    st[1] = mk_s(0, 1, 0, 0, 7);  ex[1] = mk_e(7, 0, 0, 0, 0);
    st[2] = mk_s(1, 1, 1, 1, 9);  ex[2] = mk_e(0, 0, 0, 0, 0);
    st[3] = mk_s(1, 0, 1, 0, 0);  ex[3] = mk_e(0, 0, 0, 0, 0);
    st[4] = mk_s(0, 0, 1, 1, 0);  ex[4] = mk_e(1, 0, 0, 0, 0);
    st[5] = mk_s(0, 0, 1, 1, 0);  ex[5] = mk_e(2, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  task automatic test_up_wrap();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got;
    exp_t  want;
    st[0] = mk_s(1, 0, 0, 0, 0);  ex[0] = mk_e(0, 0, 0, 0, 0);
    st[1] = mk_s(0, 1, 0, 0, 10); ex[1] = mk_e(10, 0, 0, 0, 0);
    st[2] = mk_s(0, 0, 1, 1, 0);  ex[2] = mk_e(11, 0, 0, 0, 0);
    st[3] = mk_s(0, 0, 1, 1, 0);  ex[3] = mk_e(0, 1, 0, 1, 1);
    st[4] = mk_s(0, 0, 1, 1, 0);  ex[4] = mk_e(1, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL up_wrap[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  task automatic test_down_wrap();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got;
    exp_t  want;
    st[0] = mk_s(1, 0, 0, 0, 0);  ex[0] = mk_e(0, 0, 0, 0, 0);
    st[1] = mk_s(0, 1, 0, 0, 1);  ex[1] = mk_e(1, 0, 0, 0, 0);
    st[2] = mk_s(0, 0, 1, 0, 0);  ex[2] = mk_e(0, 0, 0, 0, 0);
    st[3] = mk_s(0, 0, 1, 0, 0);  ex[3] = mk_e(11, 1, 0, 1, 1);
    st[4] = mk_s(0, 0, 1, 0, 0);  ex[4] = mk_e(10, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL down_wrap[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  task automatic test_illegal_load();
    stim_t st[8];
    exp_t  ex[8];
    exp_t  got;
    exp_t  want;
    st[0] = mk_s(1, 0, 0, 0, 0);  ex[0] = mk_e(0, 0, 0, 0, 0);
    st[1] = mk_s(0, 1, 0, 0, 5);  ex[1] = mk_e(5, 0, 0, 0, 0);
    st[2] = mk_s(0, 1, 1, 1, 13); ex[2] = mk_e(5, 0, 1, 0, 0);
    st[3] = mk_s(0, 0, 1, 1, 0);  ex[3] = mk_e(6, 0, 0, 0, 0);
    st[4] = mk_s(0, 1, 0, 0, 12); ex[4] = mk_e(6, 0, 1, 0, 0);
    st[5] = mk_s(0, 1, 0, 0, 11); ex[5] = mk_e(11, 0, 0, 0, 0);
    st[6] = mk_s(0, 1, 1, 0, 15); ex[6] = mk_e(11, 0, 1, 0, 0);
    st[7] = mk_s(0, 0, 1, 0, 0);  ex[7] = mk_e(10, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL illegal_load[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  task automatic test_load_priority();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got;
    exp_t  want;
    st[0] = mk_s(1, 0, 0, 0, 0);  ex[0] = mk_e(0, 0, 0, 0, 0);
    st[1] = mk_s(0, 1, 0, 0, 11); ex[1] = mk_e(11, 0, 0, 0, 0);
    st[2] = mk_s(0, 1, 1, 1, 3);  ex[2] = mk_e(3, 0, 0, 0, 0);
    st[3] = mk_s(0, 1, 1, 0, 0);  ex[3] = mk_e(0, 0, 0, 0, 0);
    st[4] = mk_s(0, 0, 1, 0, 0);  ex[4] = mk_e(11, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL load_priority[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  // Hold with en=0, direction toggles between edges, and back-to-back opposite wraps.
  task automatic test_back_to_back();
    stim_t st[11];
    exp_t  ex[11];
    exp_t  got;
    exp_t  want;
    st[0]  = mk_s(1, 0, 0, 0, 0);  ex[0]  = mk_e(0, 0, 0, 0, 0);
    st[1]  = mk_s(0, 1, 0, 0, 6);  ex[1]  = mk_e(6, 0, 0, 0, 0);
    st[2]  = mk_s(0, 0, 0, 1, 0);  ex[2]  = mk_e(6, 0, 0, 0, 0);
    st[3]  = mk_s(0, 0, 0, 0, 0);  ex[3]  = mk_e(6, 0, 0, 0, 0);
    st[4]  = mk_s(0, 0, 1, 1, 0);  ex[4]  = mk_e(7, 0, 0, 0, 0);
    st[5]  = mk_s(0, 0, 1, 0, 0);  ex[5]  = mk_e(6, 0, 0, 0, 0);
    st[6]  = mk_s(0, 0, 1, 1, 0);  ex[6]  = mk_e(7, 0, 0, 0, 0);
    st[7]  = mk_s(0, 1, 0, 0, 0);  ex[7]  = mk_e(0, 0, 0, 0, 0);
    st[8]  = mk_s(0, 0, 1, 0, 0);  ex[8]  = mk_e(11, 1, 0, 1, 1);
    st[9]  = mk_s(0, 0, 1, 1, 0);  ex[9]  = mk_e(0, 1, 0, 2, 2);
    st[10] = mk_s(0, 0, 0, 1, 0);  ex[10] = mk_e(0, 0, 0, 2, 2);
    for (int i = 0; i < 11; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  // Five up-wraps: the WRAP_W=2 instance stops at 3, the default one reaches 5.
  task automatic test_saturation();
    stim_t st[13];
    exp_t  ex[13];
    exp_t  got;
    exp_t  want;
    int    sat_before[5] = '{0, 1, 2, 3, 3};
    int    sat_after[5]  = '{1, 2, 3, 3, 3};
    st[0] = mk_s(1, 0, 0, 0, 0);  ex[0] = mk_e(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      st[1 + 2 * k] = mk_s(0, 1, 0, 0, 11);
      ex[1 + 2 * k] = mk_e(11, 0, 0, k, sat_before[k]);
      st[2 + 2 * k] = mk_s(0, 0, 1, 1, 0);
      ex[2 + 2 * k] = mk_e(0, 1, 0, k + 1, sat_after[k]);
    end
    st[11] = mk_s(1, 0, 1, 1, 0);  ex[11] = mk_e(0, 0, 0, 0, 0);
    st[12] = mk_s(0, 0, 1, 1, 0);  ex[12] = mk_e(1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      drive(st[i], ex[i]);
      got  = observed();
      want = sb.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL saturation[%0d]: got d_out=%0d wrap=%b err=%b cnt=%0d cnt_s=%0d, want %0d %b %b %0d %0d",
                 i, got.d_out, got.wrap, got.err, got.cnt, got.cnt_s,
                 want.d_out, want.wrap, want.err, want.cnt, want.cnt_s);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    en     = 1'b0;
    updown = 1'b0;
    d_in   = 4'd0;
    @(posedge clock);
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_illegal_load();
    test_load_priority();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
